// File: rtl/uart_prog_loader_if.sv
// Program RAM write port driven by the serial boot loader.
// Latency: n/a (wires only); the loader drives, the RAM samples on CLK.
// Backpressure: none; the RAM accepts every ram_we pulse unconditionally.
interface uart_prog_loader_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [31:0]           ram_wdata;

    modport master (output ram_we, ram_waddr, ram_wdata);
    modport slave  (input  ram_we, ram_waddr, ram_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// Serial (8N1) boot loader: parses A5/len/words[/csum] frames and writes program RAM.
// Latency: ram_we at most 2 cycles after the stop-bit sample of a word's 4th byte.
// Backpressure: none; the RAM always accepts. LOADER_CHECKSUM_EN adds the CSUM byte check.
module uart_prog_loader #(
    parameter int CLK_DIV    = 139,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ser_rx,
    uart_prog_loader_if.master    ram,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [15:0] DIV_FULL  = 16'(CLK_DIV);
    localparam logic [15:0] DIV_HALF  = 16'(CLK_DIV / 2);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        P_SYNC,
        P_LEN_HI,
        P_LEN_LO,
        P_DATA,
`ifdef LOADER_CHECKSUM_EN
        P_CSUM,
`endif
        P_DONE,
        P_ERR
    } p_state_t;

    // Where the frame goes once the last word (or an empty image) is in.
`ifdef LOADER_CHECKSUM_EN
    localparam p_state_t P_AFTER_DATA = P_CSUM;
`else
    localparam p_state_t P_AFTER_DATA = P_DONE;
`endif

    // ---------------- serial deserializer ----------------
    logic        rx_meta, rx_sync, rx_prev;
    rx_state_t   rx_state, rx_next;
    logic [15:0] rx_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        rx_fall, cnt_expire;
    logic        byte_vld, frame_err;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall    = rx_prev & ~rx_sync;
    assign cnt_expire = (rx_cnt == 16'd1);

    // RX state register.
    always_ff @(posedge CLK) begin
        if (RST) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // RX next-state: a start bit that is high again at mid-bit is a glitch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (cnt_expire) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_expire && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (cnt_expire) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Bit timer and LSB-first shift register; first sample lands mid start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_cnt   <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else if (rx_state == RX_IDLE) begin
            if (rx_fall) begin
                rx_cnt  <= DIV_HALF;
                bit_idx <= '0;
            end
        end else if (cnt_expire) begin
            rx_cnt <= DIV_FULL;
            if (rx_state == RX_DATA) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                bit_idx  <= bit_idx + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt - 16'd1;
        end
    end

    // RX outputs: byte strobe or framing error at the stop-bit sample.
    always_comb begin
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        if (rx_state == RX_STOP && cnt_expire) begin
            byte_vld  = rx_sync;
            frame_err = ~rx_sync;
        end
    end

    // ---------------- frame parser ----------------
    p_state_t              p_state, p_next;
    logic [15:0]           len;
    logic [1:0]            byte_idx;
    logic [23:0]           asm_word;
    logic [15:0]           n_field;
    logic                  too_big, n_zero, last_word;
    logic [ADDR_WIDTH:0]   wl_inc;

    assign n_field   = {len[15:8], rx_shift};
    assign too_big   = ({1'b0, n_field} > MAX_WORDS);
    assign n_zero    = (n_field == 16'd0);
    assign wl_inc    = words_loaded + (ADDR_WIDTH+1)'(1);
    assign last_word = (17'(wl_inc) == {1'b0, len});

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running mod-256 sum of the length and data bytes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            csum <= '0;
        end else if (byte_vld) begin
            case (p_state)
                P_SYNC, P_ERR:             if (rx_shift == SYNC_BYTE) csum <= '0;
                P_LEN_HI, P_LEN_LO, P_DATA: csum <= csum + rx_shift;
                default: ;
            endcase
        end
    end
`endif

    // Parser state register.
    always_ff @(posedge CLK) begin
        if (RST) p_state <= P_SYNC;
        else     p_state <= p_next;
    end

    // Parser next-state: a framing error aborts any frame not yet accepted.
    always_comb begin
        p_next = p_state;
        if (frame_err) begin
            if (p_state != P_DONE) p_next = P_ERR;
        end else if (byte_vld) begin
            case (p_state)
                P_SYNC, P_ERR: if (rx_shift == SYNC_BYTE) p_next = P_LEN_HI;
                P_LEN_HI:      p_next = P_LEN_LO;
                P_LEN_LO: begin
                    if (too_big)     p_next = P_ERR;
                    else if (n_zero) p_next = P_AFTER_DATA;
                    else             p_next = P_DATA;
                end
                P_DATA:        if (byte_idx == 2'd3 && last_word) p_next = P_AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
                P_CSUM:        p_next = (rx_shift == csum) ? P_DONE : P_ERR;
`endif
                default:       p_next = p_state;
            endcase
        end
    end

    // Parser datapath: length capture, word assembly and the RAM write pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ram.ram_we    <= 1'b0;
            ram.ram_waddr <= '0;
            ram.ram_wdata <= '0;
            words_loaded  <= '0;
            len           <= '0;
            byte_idx      <= '0;
            asm_word      <= '0;
        end else begin
            ram.ram_we <= 1'b0;
            if (byte_vld) begin
                case (p_state)
                    P_SYNC, P_ERR: begin
                        if (rx_shift == SYNC_BYTE) begin
                            words_loaded <= '0;
                            byte_idx     <= '0;
                        end
                    end
                    P_LEN_HI: len[15:8] <= rx_shift;
                    P_LEN_LO: begin
                        len[7:0] <= rx_shift;
                        byte_idx <= '0;
                    end
                    P_DATA: begin
                        if (byte_idx == 2'd3) begin
                            ram.ram_we    <= 1'b1;
                            ram.ram_waddr <= words_loaded[ADDR_WIDTH-1:0];
                            ram.ram_wdata <= {asm_word, rx_shift};
                            words_loaded  <= wl_inc;
                            byte_idx      <= '0;
                        end else begin
                            asm_word <= {asm_word[15:0], rx_shift};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status decode: DONE is terminal until reset, so load_done is sticky.
    always_comb begin
        cpu_hold   = (p_state != P_DONE);
        load_done  = (p_state == P_DONE);
        load_error = (p_state == P_ERR);
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: frame table plus reset/glitch sequences.
// Latency: writes are checked by a scoreboard as they appear on the RAM port.
// Backpressure: none; the bench drives the serial line at a fixed bit rate.
module tb_uart_prog_loader;

    localparam int CLK_DIV = 16;
    localparam int AW      = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ser_rx = 1'b1;
    logic          cpu_hold, load_done, load_error;
    logic [AW:0]   words_loaded;

    uart_prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_prog_loader #(.CLK_DIV(CLK_DIV), .ADDR_WIDTH(AW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ser_rx       (ser_rx),
        .ram          (bus),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    typedef struct {
        logic [15:0] n;
        int          kind;
        logic [7:0]  delta;
        bit          hdr_only;
        bit          bad_stop;
        bit          garbage;
        bit          rst_before;
        bit          exp_done;
        bit          exp_err;
        int          exp_wl;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ram_we"},    32'(bus.ram_we),       32'd0);
        check({tag, "_ram_waddr"}, 32'(bus.ram_waddr),    32'd0);
        check({tag, "_ram_wdata"}, bus.ram_wdata,         32'd0);
        check({tag, "_cpu_hold"},  32'(cpu_hold),         32'd1);
        check({tag, "_load_done"}, 32'(load_done),        32'd0);
        check({tag, "_load_err"},  32'(load_error),       32'd0);
        check({tag, "_words"},     32'(words_loaded),     32'd0);
    endtask

    task automatic check_status(input string tag, input bit done, input bit err, input int wl);
        check({tag, "_load_done"}, 32'(load_done),    32'(done));
        check({tag, "_load_err"},  32'(load_error),   32'(err));
        check({tag, "_cpu_hold"},  32'(cpu_hold),     32'(!done));
        check({tag, "_words"},     32'(words_loaded), 32'(wl));
        check({tag, "_pending_wr"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        ser_rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            tick(CLK_DIV);
        end
        ser_rx = stop_v;
        tick(CLK_DIV);
        ser_rx = 1'b1;
        tick(2);
    endtask

    function automatic logic [31:0] word_of(input int kind, input int i);
        if (kind == 0) return (i == 0) ? 32'hDEADBEEF : 32'h0000002A;
        return {8'(i), 8'(8'hFF ^ 8'(i)), 8'(i * 7), 8'h5A};
    endfunction

    // Sends one frame; expected RAM writes are queued just before the word's last byte.
    task automatic send_frame(input logic [15:0] n, input int kind, input logic [7:0] delta,
                              input bit hdr_only, input bit bad_stop, input bit garbage);
        logic [7:0]  cs;
        logic [31:0] w;
        if (garbage) begin
            send_byte(8'h00, 1'b1);
            send_byte(8'hFF, 1'b1);
            send_byte(8'h12, 1'b1);
        end
        cs = n[15:8] + n[7:0];
        send_byte(8'hA5, 1'b1);
        send_byte(n[15:8], 1'b1);
        send_byte(n[7:0], !bad_stop);
        if (!hdr_only) begin
            for (int i = 0; i < int'(n); i++) begin
                w = word_of(kind, i);
                for (int k = 3; k >= 0; k--) begin
                    if (k == 0) exp_q.push_back({4'(i), w});
                    send_byte(w[8*k +: 8], 1'b1);
                    cs = cs + w[8*k +: 8];
                end
            end
            if (CSUM_EN) send_byte(8'(cs + delta), 1'b1);
        end
        tick(4);
    endtask

    // Scoreboard: every RAM write must match the oldest queued expectation.
    task automatic monitor();
        logic [35:0] e;
        forever begin
            @(negedge CLK);
            if (bus.ram_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                             bus.ram_waddr, bus.ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.ram_waddr), 32'(e[35:32]));
                    check("wr_data", bus.ram_wdata, e[31:0]);
                end
            end
        end
    endtask

    initial begin
        //           n       kind delta hdr  bstop garb rst        done      err      wl
        vecs[0] = '{16'h0002, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,     1'b0,    2};
        vecs[1] = '{16'h0002, 0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, !CSUM_EN, CSUM_EN, 2};
        vecs[2] = '{16'h0002, 0, 8'h00, 1'b0, 1'b0, 1'b0, !CSUM_EN, 1'b1, 1'b0,    2};
        vecs[3] = '{16'h0002, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,     1'b0,    2};
        vecs[4] = '{16'h0002, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,     1'b1,    0};
        vecs[5] = '{16'h0011, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,     1'b1,    0};
        vecs[6] = '{16'h0010, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,     1'b0,    16};
        vecs[7] = '{16'h0000, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,     1'b0,    0};

        fork
            monitor();
        join_none

        do_reset();
        check_reset_vals("reset");

        // Short low pulse on the idle line must not be taken as a start bit.
        ser_rx = 1'b0;
        tick(4);
        ser_rx = 1'b1;
        tick(4 * CLK_DIV);
        check_status("glitch", 1'b0, 1'b0, 0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_before) do_reset();
            send_frame(vecs[v].n, vecs[v].kind, vecs[v].delta,
                       vecs[v].hdr_only, vecs[v].bad_stop, vecs[v].garbage);
            check_status($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_wl);
        end

        // Reset after the 5th data byte: first word written, the rest abandoned.
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        exp_q.push_back({4'd0, 32'hDEADBEEF});
        send_byte(8'hEF, 1'b1);
        send_byte(8'h00, 1'b1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check_reset_vals("midrst");
        tick(40 * CLK_DIV);
        check_status("midrst_idle", 1'b0, 1'b0, 0);
        send_frame(16'h0002, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_status("midrst_reload", 1'b1, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
